// File: rtl/game_pkg.sv
// Shared colours, screen geometry and judge enums for the lane logic.
package game_pkg;

  localparam logic [5:0] C_NONE  = 6'b000000;
  localparam logic [5:0] C_GREEN = 6'b001100;
  localparam logic [5:0] C_WHITE = 6'b111111;
  localparam logic [5:0] C_RED   = 6'b110000;

  localparam int VISIBLE_ROWS = 480;
  localparam int VISIBLE_COLS = 640;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    HIT_HOLD = 2'd2
  } judge_state_t;

  typedef enum logic {
    HIT  = 1'b0,
    MISS = 1'b1
  } flash_kind_t;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser + debouncer; press pulses 2+DEBOUNCE_CYCLES cycles after a clean rising edge.
// A level held through reset must first be seen low before a press is reported; no backpressure.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;
  logic          low_seen_q, low_seen_d;
  logic          press_q, press_d;

  always_comb begin
    sync_d     = {sync_q[0], btn};
    cnt_d      = cnt_q;
    stable_d   = stable_q;
    low_seen_d = low_seen_q;
    press_d    = 1'b0;
    // sync_q[0] is next cycle's synchronised level, so a mismatch is a change
    if (sync_q[0] != sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      stable_d = sync_q[1];
      if (!sync_q[1]) low_seen_d = 1'b1;
      press_d = sync_q[1] && !stable_q && low_seen_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      stable_q   <= 1'b0;
      low_seen_q <= 1'b0;
      press_q    <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      stable_q   <= stable_d;
      low_seen_q <= low_seen_d;
      press_q    <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/lane_hit_judge.sv
// Per-frame note-in-zone flag, hit/miss judgement of debounced presses, score/combo and zone flash.
// Pulses one cycle after the judging condition; judge_rgb is combinational; no backpressure.
module lane_hit_judge
  import game_pkg::*;
#(
  parameter int HIT_TOP         = 440,
  parameter int HIT_BOT         = 470,
  parameter int SAMPLE_COL      = 100,
  parameter int FRAME_ROW       = VISIBLE_ROWS,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FLASH_FRAMES    = 4,
  parameter int SCORE_W         = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         col,
  input  logic [9:0]         row,
  input  logic               valid,
  input  logic [5:0]         lane_rgb,
  input  logic               btn,
  output logic               hit_pulse,
  output logic               miss_pulse,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [5:0]         judge_rgb
);

  localparam int FW = $clog2(FLASH_FRAMES + 1);

  logic               press;
  logic               in_zone, frame_tick;
  logic               seen_frame_q, seen_frame_d;
  logic               note_present_q, note_present_d;
  judge_state_t       state_q, state_d;
  logic               hit_q, hit_d, miss_q, miss_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [7:0]         combo_q, combo_d;
  logic [FW-1:0]      flash_cnt_q, flash_cnt_d;
  flash_kind_t        flash_kind_q, flash_kind_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .press (press)
  );

  always_comb begin
    in_zone    = (row >= 10'(HIT_TOP)) && (row <= 10'(HIT_BOT));
    frame_tick = (row == 10'(FRAME_ROW)) && (col == 10'd0);

    seen_frame_d   = seen_frame_q;
    note_present_d = note_present_q;
    if (frame_tick) begin
      note_present_d = seen_frame_q;
      seen_frame_d   = 1'b0;
    end else if (valid && col == 10'(SAMPLE_COL) && in_zone && lane_rgb != 6'd0) begin
      seen_frame_d = 1'b1;
    end

    state_d = state_q;
    hit_d   = 1'b0;
    miss_d  = 1'b0;
    score_d = score_q;
    combo_d = combo_q;
    case (state_q)
      IDLE: if (note_present_q) state_d = ARMED;
      ARMED: begin
        // a press landing as the note leaves still counts as a hit
        if (press) begin
          hit_d   = 1'b1;
          score_d = (score_q == '1) ? score_q : score_q + 1'b1;
          combo_d = (combo_q == 8'hFF) ? combo_q : combo_q + 1'b1;
          state_d = HIT_HOLD;
        end else if (!note_present_q) begin
          miss_d  = 1'b1;
          combo_d = 8'd0;
          state_d = IDLE;
        end
      end
      HIT_HOLD: if (!note_present_q) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    flash_cnt_d  = flash_cnt_q;
    flash_kind_d = flash_kind_q;
    if (hit_q) begin
      flash_cnt_d  = FW'(FLASH_FRAMES);
      flash_kind_d = HIT;
    end else if (miss_q) begin
      flash_cnt_d  = FW'(FLASH_FRAMES);
      flash_kind_d = MISS;
    end else if (frame_tick && flash_cnt_q != '0) begin
      flash_cnt_d = flash_cnt_q - 1'b1;
    end

    judge_rgb = C_NONE;
    if (valid && in_zone && flash_cnt_q != '0) begin
      judge_rgb = (flash_kind_q == HIT) ? C_WHITE : C_RED;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_frame_q   <= 1'b0;
      note_present_q <= 1'b0;
      state_q        <= IDLE;
      hit_q          <= 1'b0;
      miss_q         <= 1'b0;
      score_q        <= '0;
      combo_q        <= 8'd0;
      flash_cnt_q    <= '0;
      flash_kind_q   <= HIT;
    end else begin
      seen_frame_q   <= seen_frame_d;
      note_present_q <= note_present_d;
      state_q        <= state_d;
      hit_q          <= hit_d;
      miss_q         <= miss_d;
      score_q        <= score_d;
      combo_q        <= combo_d;
      flash_cnt_q    <= flash_cnt_d;
      flash_kind_q   <= flash_kind_d;
    end
  end

  assign hit_pulse  = hit_q;
  assign miss_pulse = miss_q;
  assign score      = score_q;
  assign combo      = combo_q;

endmodule

// File: tb/tb_lane_hit_judge.sv
// Bench for lane_hit_judge: compressed scan (rows 420..499, sample column only) plus scoreboarded judgements.
module tb_lane_hit_judge;
  import game_pkg::*;

  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst, valid, btn;
  logic [9:0]    col, row;
  logic [5:0]    lane_rgb;
  logic          hit_pulse, miss_pulse;
  logic [SW-1:0] score;
  logic [7:0]    combo;
  logic [5:0]    judge_rgb;

  lane_hit_judge #(.SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row), .valid(valid), .lane_rgb(lane_rgb),
    .btn(btn), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .score(score),
    .combo(combo), .judge_rgb(judge_rgb)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct { bit is_hit; int score; int combo; } exp_t;
  exp_t sb_q[$];
  exp_t sb_e;
  int   exp_score = 0;
  int   exp_combo = 0;

  task automatic push_exp(input bit h, input int s, input int c);
    exp_t e;
    e.is_hit = h; e.score = s; e.combo = c;
    sb_q.push_back(e);
  endtask

  // Frame schedule: note pixels in rows 445..460 of frame f when note_sched[f] is set.
  bit note_sched [0:511];
  int fidx = 0;
  bit scan_en = 0;

  initial begin
    col = 10'd0; row = 10'd0; valid = 1'b0; lane_rgb = C_NONE;
    wait (scan_en);
    forever begin
      for (int r = 420; r < 500; r++) begin
        @(negedge clk);
        row      = 10'(r);
        col      = (r == 480) ? 10'd0 : 10'd100;
        valid    = (r < 480);
        lane_rgb = (note_sched[fidx] && r >= 445 && r <= 460) ? C_GREEN : C_NONE;
      end
      fidx++;
    end
  end

  int pcnt = 0, ticks = 0, tick_pc = 0;
  int hit_cnt = 0, miss_cnt = 0, press_cnt = 0, hit_pc = 0, miss_pc = 0, press_pc = 0;

  always @(posedge clk) pcnt++;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (row == 10'd480 && col == 10'd0) begin ticks++; tick_pc = pcnt; end
      if (dut.press) begin press_cnt++; press_pc = pcnt; end
      if (hit_pulse || miss_pulse) begin
        check_eq("pulse_overlap", int'(hit_pulse && miss_pulse), 0);
        if (hit_pulse)  begin hit_cnt++;  hit_pc  = pcnt; end
        if (miss_pulse) begin miss_cnt++; miss_pc = pcnt; end
        check_eq("sb_pending", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          sb_e = sb_q.pop_front();
          check_eq("sb_kind",  int'(hit_pulse), int'(sb_e.is_hit));
          check_eq("sb_score", int'(score), sb_e.score);
          check_eq("sb_combo", int'(combo), sb_e.combo);
        end
      end
    end
  end

  task automatic wait_tick();
    int t0;
    t0 = ticks;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (ticks != t0) return;
    end
    check_eq("tick_timeout", ticks - t0, 1);
  endtask

  task automatic grab(input int r, output int v);
    v = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (row == 10'(r)) begin v = int'(judge_rgb); return; end
    end
    check_eq("row_timeout", int'(row), r);
  endtask

  // Note in the next whole frame, clean press 10 cycles after its tick; returns btn-edge to hit_pulse cycles.
  task automatic do_hit(output int lat);
    int h0, p0;
    lat = -1;
    wait_tick();
    note_sched[ticks] = 1'b1;
    wait_tick();
    repeat (10) @(negedge clk);
    exp_score = (exp_score < SMAX) ? exp_score + 1 : exp_score;
    exp_combo = (exp_combo < 255) ? exp_combo + 1 : exp_combo;
    push_exp(1'b1, exp_score, exp_combo);
    h0 = hit_cnt;
    btn = 1'b1;
    p0 = pcnt;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (hit_cnt != h0) begin lat = hit_pc - p0; break; end
    end
    @(negedge clk);
    btn = 1'b0;
  endtask

  int lat, v, h0, pr0, m0, plast;

  initial begin
    rst = 1'b1;
    btn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_hit",   int'(hit_pulse), 0);
    check_eq("rst_miss",  int'(miss_pulse), 0);
    check_eq("rst_score", int'(score), 0);
    check_eq("rst_combo", int'(combo), 0);
    check_eq("rst_rgb",   int'(judge_rgb), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_eq("held_btn_no_press", press_cnt, 0);
    btn = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("release_no_press", press_cnt, 0);
    scan_en = 1'b1;

    // Single hit: latency, score/combo, white flash in rows 440..470 for 4 frames
    do_hit(lat);
    check_eq("hit_latency", lat, 19);
    check_eq("hit_score", int'(score), 1);
    check_eq("hit_combo", int'(combo), 1);
    grab(438, v); check_eq("flash_row438", v, 0);
    grab(440, v); check_eq("flash_row440", v, int'(C_WHITE));
    grab(470, v); check_eq("flash_row470", v, int'(C_WHITE));
    grab(471, v); check_eq("flash_row471", v, 0);
    for (int f = 0; f < 3; f++) begin
      grab(450, v); check_eq("flash_hit_frame", v, int'(C_WHITE));
    end
    grab(450, v); check_eq("flash_hit_expired", v, 0);

    // Three presses on one note spanning 3 frames
    wait_tick();
    for (int j = 0; j < 3; j++) note_sched[ticks + j] = 1'b1;
    wait_tick();
    h0 = hit_cnt; pr0 = press_cnt; m0 = miss_cnt;
    exp_score++; exp_combo++;
    push_exp(1'b1, exp_score, exp_combo);
    repeat (10) @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      btn = 1'b1; repeat (30) @(negedge clk);
      btn = 1'b0; repeat (40) @(negedge clk);
    end
    check_eq("multi_press_count", press_cnt - pr0, 3);
    check_eq("multi_hit_once", hit_cnt - h0, 1);
    check_eq("multi_state_hold", int'(dut.state_q), int'(HIT_HOLD));
    wait_tick();
    repeat (3) @(posedge clk);
    #2;
    check_eq("multi_state_idle", int'(dut.state_q), int'(IDLE));
    check_eq("multi_no_miss", miss_cnt - m0, 0);
    check_eq("multi_score", int'(score), 2);

    do_hit(lat);
    check_eq("third_combo", int'(combo), 3);

    // Note for 3 frames, never pressed: one miss right after the 4th tick
    wait_tick();
    for (int j = 0; j < 3; j++) note_sched[ticks + j] = 1'b1;
    m0 = miss_cnt;
    push_exp(1'b0, exp_score, 0);
    exp_combo = 0;
    repeat (4) wait_tick();
    repeat (4) @(posedge clk);
    #2;
    check_eq("miss_once", miss_cnt - m0, 1);
    check_eq("miss_latency", miss_pc - tick_pc, 1);
    check_eq("miss_score", int'(score), 3);
    for (int f = 0; f < 4; f++) begin
      grab(450, v); check_eq("flash_miss_frame", v, int'(C_RED));
    end
    grab(450, v); check_eq("flash_miss_expired", v, 0);

    // Bouncing button with no note: one press 18 cycles after the last edge, ignored in IDLE
    pr0 = press_cnt; h0 = hit_cnt;
    for (int j = 0; j < 12; j++) begin
      btn = ~btn;
      repeat (5) @(negedge clk);
    end
    btn = 1'b1;
    plast = pcnt;
    repeat (40) @(negedge clk);
    check_eq("bounce_one_press", press_cnt - pr0, 1);
    check_eq("bounce_latency", press_pc - plast, 18);
    check_eq("idle_press_no_hit", hit_cnt - h0, 0);
    check_eq("idle_press_combo", int'(combo), 0);
    btn = 1'b0;
    repeat (30) @(negedge clk);

    // 20 hits into a 4-bit score
    h0 = hit_cnt;
    for (int k = 0; k < 20; k++) do_hit(lat);
    repeat (5) @(posedge clk);
    #2;
    check_eq("sat_hits", hit_cnt - h0, 20);
    check_eq("sat_score", int'(score), SMAX);
    check_eq("sat_combo", int'(combo), 20);

    repeat (100) @(posedge clk);
    #2;
    check_eq("sb_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lane_hit_judge.md
Name: lane_hit_judge

Overview:
- Downstream consumer of one falling-note lane's pixel stream.
- Samples the lane's `lane_rgb` in a fixed hit zone while the VGA scan passes, and latches "note in zone" once per frame.
- Judges a synchronised, debounced player button press against that flag, producing hit/miss pulses, a saturating score and combo count, and a hit-zone flash overlay for the pixel mixer.

Parameters:
- HIT_TOP, 440, first row (inclusive) of the hit zone.
- HIT_BOT, 470, last row (inclusive) of the hit zone.
- SAMPLE_COL, 100, column at which `lane_rgb` is sampled.
- FRAME_ROW, 480, row at which the per-frame flag is transferred (first non-visible row).
- DEBOUNCE_CYCLES, 16, cycles `btn` must be stable before it is accepted.
- FLASH_FRAMES, 4, frames the hit/miss flash stays lit.
- SCORE_W, 10, score counter width.

Ports:
- clk  in  1  pixel clock; one col/row step per cycle.
- rst  in  1  asynchronous, active-high reset.
- col  in  10  current scan column.
- row  in  10  current scan row.
- valid  in  1  visible-area indicator.
- lane_rgb  in  6  lane pixel colour; nonzero means note pixel.
- btn  in  1  raw asynchronous player button.
- hit_pulse  out  1  one-cycle pulse per judged hit.
- miss_pulse  out  1  one-cycle pulse per judged miss.
- score  out  SCORE_W  hit count, saturating at all-ones.
- combo  out  8  consecutive hits, saturating at 255, cleared on miss.
- judge_rgb  out  6  hit-zone overlay colour; 0 = transparent.

Behaviour:
- Reset (async, active-high): all outputs are 0; FSM is IDLE; synchroniser, debounce, flag and flash registers are 0.
- Sampling:
  - `seen_frame` sets when valid && col==SAMPLE_COL && HIT_TOP<=row<=HIT_BOT && lane_rgb!=0.
  - `frame_tick` = (row==FRAME_ROW && col==0), one cycle per frame.
  - On `frame_tick`: `note_present` <= `seen_frame` and `seen_frame` <= 0.
  - `note_present` changes only on `frame_tick`.
- Button path:
  - 2-FF synchroniser, then a debounce counter.
  - The counter resets on any change of the synchronised level; when it reaches DEBOUNCE_CYCLES-1 the stable level is updated.
  - `press` is a one-cycle pulse on a 0->1 transition of the stable level.
  - Latency from a clean `btn` edge to `press`: 2+DEBOUNCE_CYCLES cycles.
- FSM states and transitions:
  - IDLE: `note_present`==1 -> ARMED. A `press` in IDLE is ignored (no pulse, no combo change).
  - ARMED, `press`: `hit_pulse`=1 for one cycle, score+1 (saturating), combo+1 (saturating), -> HIT_HOLD.
  - ARMED, `note_present`==0 with no `press`: `miss_pulse`=1 for one cycle, combo <= 0, -> IDLE.
  - ARMED, `press` and `note_present` fall in the same cycle: press wins -> hit, -> HIT_HOLD.
  - HIT_HOLD: further presses ignored; `note_present`==0 -> IDLE. This prevents scoring one note twice.
- Pulses are registered: they assert in the cycle after the triggering condition. `score` and `combo` update in the same cycle as the pulse.
- Flash:
  - On `hit_pulse`: `flash_cnt` <= FLASH_FRAMES, `flash_kind` <= HIT.
  - On `miss_pulse`: `flash_cnt` <= FLASH_FRAMES, `flash_kind` <= MISS.
  - `flash_cnt` decrements on each `frame_tick` while nonzero. A reload in the same cycle as `frame_tick` takes priority over the decrement.
  - `judge_rgb` = colour when valid && HIT_TOP<=row<=HIT_BOT && `flash_cnt`!=0, else 0. Colour is 6'b111111 for HIT, 6'b110000 for MISS.
  - `judge_rgb` is combinational from registered state and the current row/valid.
- Reset mid-frame: everything clears; the first judgement can occur only after the next `frame_tick` sets `note_present`.

Decomposition:
- Package `game_pkg`:
  - Colour constants: C_NONE, C_GREEN=6'b001100, C_WHITE, C_RED.
  - Screen constants: VISIBLE_ROWS=480, VISIBLE_COLS=640.
  - Enum `judge_state_t` {IDLE, ARMED, HIT_HOLD}.
  - Enum `flash_kind_t` {HIT, MISS}.
- Sub-module `btn_debounce`: synchroniser, debounce counter and rising-edge pulse, parameterised by DEBOUNCE_CYCLES.

Test Plan:
- Reset with `btn` held high: all outputs 0; no `press` generated until `btn` goes low and then high again.
- Note pixels at rows 445-460 of frame N, clean press 10 cycles after frame N's tick: `hit_pulse` once, score 0->1, combo 0->1, `judge_rgb`=6'b111111 inside rows 440-470 for exactly 4 frames.
- Note present for frames N..N+2, no press: `miss_pulse` once after frame N+3's tick, combo 3->0, score unchanged, `judge_rgb`=6'b110000 for 4 frames.
- Three presses while one note stays in the zone for 3 frames: exactly one `hit_pulse`, score +1; the FSM remains in HIT_HOLD until `note_present` drops.
- `btn` bouncing (toggling every 5 cycles for 60 cycles, then stable high, DEBOUNCE_CYCLES=16): exactly one `press`, 18 cycles after the last edge.
- Score preset near saturation (SCORE_W=4) and 20 hits: score stops at 15; combo reaches 20; `hit_pulse` still fires 20 times.
